// File: rtl/deferred_light_accum_if.sv
// Sample, light-table config and result handshake bundle for deferred_light_accum.
// The master side drives samples and config; the slave side is the lighting core.
interface deferred_light_accum_if #(
  parameter int unsigned W    = 16,
  parameter int unsigned LI_W = 2,
  parameter int unsigned NL_W = 3
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [W-1:0]    albedo_r, albedo_g, albedo_b;
  logic signed [W-1:0]    nx, ny, nz;
  logic        [7:0]      spec_scale;
  logic        [3:0]      shininess;
  logic        [NL_W-1:0] num_lights;
  logic                   cfg_we;
  logic        [LI_W-1:0] cfg_idx;
  logic signed [W-1:0]    cfg_lx, cfg_ly, cfg_lz, cfg_int;
  logic                   out_valid;
  logic                   out_ready;
  logic        [W-1:0]    out_r, out_g, out_b;
  logic                   busy;

  modport master (
    output in_valid, albedo_r, albedo_g, albedo_b, nx, ny, nz,
           spec_scale, shininess, num_lights,
           cfg_we, cfg_idx, cfg_lx, cfg_ly, cfg_lz, cfg_int, out_ready,
    input  in_ready, out_valid, out_r, out_g, out_b, busy
  );

  modport slave (
    input  in_valid, albedo_r, albedo_g, albedo_b, nx, ny, nz,
           spec_scale, shininess, num_lights,
           cfg_we, cfg_idx, cfg_lx, cfg_ly, cfg_lz, cfg_int, out_ready,
    output in_ready, out_valid, out_r, out_g, out_b, busy
  );
endinterface

// File: rtl/deferred_light_accum.sv
// Multi-light deferred shading: per light, clamped N.L diffuse plus Blinn N.H^s specular,
// accumulated per RGB channel with saturation; one G-buffer sample in flight at a time.
module deferred_light_accum #(
  parameter int unsigned W          = 16,
  parameter int unsigned MAX_LIGHTS = 4,
  parameter int unsigned LI_W       = $clog2(MAX_LIGHTS),
  parameter int unsigned NL_W       = $clog2(MAX_LIGHTS + 1)
) (
  input logic              clk,
  input logic              rst,
  deferred_light_accum_if.slave bus
);
  localparam int unsigned DW = W + 3;
  localparam int unsigned PW = 2 * W + 2;
  localparam int unsigned MW = 2 * W + 6;
  localparam int unsigned AW = W + 2;
  localparam logic signed [W:0]  ONE_E   = (W + 1)'((1 << (W - 1)) - 1);
  localparam logic [AW-1:0]      ONE_A   = AW'((1 << (W - 1)) - 1);
  localparam logic [AW-1:0]      ACC_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_DOT, S_POW, S_ACC, S_OUT} state_t;

  state_t                state_q, state_d;
  logic signed [W-1:0]   tbl_lx_q [MAX_LIGHTS];
  logic signed [W-1:0]   tbl_ly_q [MAX_LIGHTS];
  logic signed [W-1:0]   tbl_lz_q [MAX_LIGHTS];
  logic signed [W-1:0]   tbl_int_q [MAX_LIGHTS];
  logic signed [W-1:0]   alb_q [3], alb_d [3];
  logic signed [W-1:0]   nx_q, ny_q, nz_q, nx_d, ny_d, nz_d;
  logic        [7:0]     ss_q, ss_d;
  logic        [3:0]     sh_q, sh_d, pow_q, pow_d;
  logic        [NL_W-1:0] nl_q, nl_d, k_q, k_d, nl_in;
  logic signed [DW-1:0]  nld_q, nld_d, ndh_q, ndh_d, spec_q, spec_d;
  logic        [AW-1:0]  acc_q [3], acc_d [3], acc_sat [3];
  logic        [W-1:0]   out_q [3], out_d [3], out_sat [3];
  logic                  out_valid_q, out_valid_d;

  logic        [LI_W-1:0] kidx;
  logic signed [W-1:0]   lx, ly, lz, li, alb_pos;
  logic signed [W:0]     lx_e, ly_e, lz_e, hx, hy, hz;
  logic signed [PW-1:0]  dot_nl, dot_nh;
  logic signed [DW-1:0]  nld_c, ndh_c, pow_next;
  logic signed [MW-1:0]  pow_p, d_c, s_c, t_c, sum_c;
  logic signed [8:0]     ss_s;

  assign nl_in = (bus.num_lights > NL_W'(MAX_LIGHTS)) ? NL_W'(MAX_LIGHTS) : bus.num_lights;

  always_comb begin
    kidx   = k_q[LI_W-1:0];
    lx     = tbl_lx_q[kidx];
    ly     = tbl_ly_q[kidx];
    lz     = tbl_lz_q[kidx];
    li     = tbl_int_q[kidx];
    lx_e   = (W + 1)'(lx);
    ly_e   = (W + 1)'(ly);
    lz_e   = (W + 1)'(lz);
    // Half vector assumes the view direction is +Z; formed one bit wider so lz+ONE cannot wrap.
    hx     = lx_e >>> 1;
    hy     = ly_e >>> 1;
    hz     = (lz_e + ONE_E) >>> 1;
    dot_nl = PW'(nx_q) * PW'(lx) + PW'(ny_q) * PW'(ly) + PW'(nz_q) * PW'(lz);
    dot_nh = PW'(nx_q) * PW'(hx) + PW'(ny_q) * PW'(hy) + PW'(nz_q) * PW'(hz);
    nld_c  = dot_nl[PW-1] ? '0 : DW'(dot_nl >>> (W - 1));
    ndh_c  = dot_nh[PW-1] ? '0 : DW'(dot_nh >>> (W - 1));
    pow_p  = MW'(spec_q) * MW'(ndh_q);
    pow_next = DW'(pow_p >>> (W - 1));
    ss_s   = $signed({1'b0, ss_q});
    alb_pos = '0;
    d_c    = '0;
    s_c    = '0;
    t_c    = '0;
    sum_c  = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      alb_pos = alb_q[c][W-1] ? '0 : alb_q[c];
      d_c     = (MW'(alb_pos) * MW'(nld_q)) >>> (W - 1);
      s_c     = (MW'(ss_s) * MW'(spec_q)) >>> 7;
      t_c     = ((d_c + s_c) * MW'(li)) >>> (W - 1);
      if (t_c[MW-1]) t_c = '0;
      sum_c   = $signed(MW'(acc_q[c])) + t_c;
      acc_sat[c] = (sum_c > $signed(MW'(ACC_MAX))) ? ACC_MAX : AW'(sum_c);
      out_sat[c] = (acc_q[c] > ONE_A) ? ONE_A[W-1:0] : acc_q[c][W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    alb_d       = alb_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    nz_d        = nz_q;
    ss_d        = ss_q;
    sh_d        = sh_q;
    pow_d       = pow_q;
    nl_d        = nl_q;
    k_d         = k_q;
    nld_d       = nld_q;
    ndh_d       = ndh_q;
    spec_d      = spec_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_IDLE: if (bus.in_valid) begin
        alb_d[0] = bus.albedo_r;
        alb_d[1] = bus.albedo_g;
        alb_d[2] = bus.albedo_b;
        nx_d     = bus.nx;
        ny_d     = bus.ny;
        nz_d     = bus.nz;
        ss_d     = bus.spec_scale;
        sh_d     = bus.shininess;
        nl_d     = nl_in;
        k_d      = '0;
        acc_d    = '{default: '0};
        state_d  = (nl_in == '0) ? S_OUT : S_DOT;
      end
      S_DOT: begin
        nld_d   = nld_c;
        ndh_d   = ndh_c;
        spec_d  = (sh_q == '0) ? '0 : ndh_c;
        pow_d   = sh_q - 4'd1;
        state_d = (sh_q > 4'd1) ? S_POW : S_ACC;
      end
      S_POW: begin
        spec_d = pow_next;
        pow_d  = pow_q - 4'd1;
        if (pow_q == 4'd1) state_d = S_ACC;
      end
      S_ACC: begin
        acc_d   = acc_sat;
        k_d     = k_q + NL_W'(1);
        state_d = (k_d < nl_q) ? S_DOT : S_OUT;
      end
      // First OUT cycle registers the clamped result; valid is then held until out_ready.
      S_OUT: begin
        if (!out_valid_q) begin
          out_d       = out_sat;
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      alb_q       <= '{default: '0};
      nx_q        <= '0;
      ny_q        <= '0;
      nz_q        <= '0;
      ss_q        <= '0;
      sh_q        <= '0;
      pow_q       <= '0;
      nl_q        <= '0;
      k_q         <= '0;
      nld_q       <= '0;
      ndh_q       <= '0;
      spec_q      <= '0;
      acc_q       <= '{default: '0};
      out_q       <= '{default: '0};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alb_q       <= alb_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      nz_q        <= nz_d;
      ss_q        <= ss_d;
      sh_q        <= sh_d;
      pow_q       <= pow_d;
      nl_q        <= nl_d;
      k_q         <= k_d;
      nld_q       <= nld_d;
      ndh_q       <= ndh_d;
      spec_q      <= spec_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_lx_q  <= '{default: '0};
      tbl_ly_q  <= '{default: '0};
      tbl_lz_q  <= '{default: '0};
      tbl_int_q <= '{default: '0};
    end else if (bus.cfg_we && state_q == S_IDLE) begin
      tbl_lx_q[bus.cfg_idx]  <= bus.cfg_lx;
      tbl_ly_q[bus.cfg_idx]  <= bus.cfg_ly;
      tbl_lz_q[bus.cfg_idx]  <= bus.cfg_lz;
      tbl_int_q[bus.cfg_idx] <= bus.cfg_int;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_r     = out_q[0];
  assign bus.out_g     = out_q[1];
  assign bus.out_b     = out_q[2];
endmodule

// File: tb/tb_deferred_light_accum.sv
// Scoreboard bench for deferred_light_accum: directed samples push hand-computed results,
// a negedge monitor compares every presented output and its latency against the queue head.
module tb_deferred_light_accum;
  localparam int unsigned W = 16, MAX_LIGHTS = 4, LI_W = 2, NL_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  deferred_light_accum_if #(.W(W), .LI_W(LI_W), .NL_W(NL_W)) bus ();

  deferred_light_accum #(.W(W), .MAX_LIGHTS(MAX_LIGHTS), .LI_W(LI_W), .NL_W(NL_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string name;
    int    r, g, b, lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   t_acc    = 0;
  bit   lat_seen = 1'b0;

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst && bus.in_valid && bus.in_ready) t_acc = cyc;
  end

  always @(negedge clk) begin
    if (rst) lat_seen = 1'b0;
    else if (bus.out_valid) begin
      if (sb.size() == 0) check("unexpected_out_valid", int'(bus.out_valid), 0);
      else begin
        if (!lat_seen) begin
          check({sb[0].name, "_latency"}, cyc - t_acc, sb[0].lat);
          lat_seen = 1'b1;
        end
        check({sb[0].name, "_r"}, int'(bus.out_r), sb[0].r);
        check({sb[0].name, "_g"}, int'(bus.out_g), sb[0].g);
        check({sb[0].name, "_b"}, int'(bus.out_b), sb[0].b);
        check({sb[0].name, "_in_ready_low"}, int'(bus.in_ready), 0);
        if (bus.out_ready) begin
          void'(sb.pop_front());
          lat_seen = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(int idx, int lx, int ly, int lz, int li);
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = LI_W'(idx);
    bus.cfg_lx  = W'(lx);
    bus.cfg_ly  = W'(ly);
    bus.cfg_lz  = W'(lz);
    bus.cfg_int = W'(li);
    tick();
    bus.cfg_we  = 1'b0;
  endtask

  task automatic issue(string name, int ar, int ag, int ab, int nz, int ss, int sh, int nl,
                       bit expect_out, int er, int eg, int eb, int lat);
    int   guard;
    exp_t e;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (!bus.in_ready) check({name, "_accept_timeout"}, int'(bus.in_ready), 1);
    bus.albedo_r   = W'(ar);
    bus.albedo_g   = W'(ag);
    bus.albedo_b   = W'(ab);
    bus.nx         = '0;
    bus.ny         = '0;
    bus.nz         = W'(nz);
    bus.spec_scale = 8'(ss);
    bus.shininess  = 4'(sh);
    bus.num_lights = NL_W'(nl);
    bus.in_valid   = 1'b1;
    if (expect_out) begin
      e.name = name;
      e.r    = er;
      e.g    = eg;
      e.b    = eb;
      e.lat  = lat;
      sb.push_back(e);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic drain(string name);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    if (sb.size() != 0) begin
      check({name, "_drain_timeout"}, sb.size(), 0);
      sb.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus.in_valid   = 1'b0;
    bus.albedo_r   = '0;
    bus.albedo_g   = '0;
    bus.albedo_b   = '0;
    bus.nx         = '0;
    bus.ny         = '0;
    bus.nz         = '0;
    bus.spec_scale = '0;
    bus.shininess  = '0;
    bus.num_lights = '0;
    bus.cfg_we     = 1'b0;
    bus.cfg_idx    = '0;
    bus.cfg_lx     = '0;
    bus.cfg_ly     = '0;
    bus.cfg_lz     = '0;
    bus.cfg_int    = '0;
    bus.out_ready  = 1'b1;
    #2 rst = 1'b1;
    tick();
    tick();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_out_r", int'(bus.out_r), 0);
    rst = 1'b0;
    tick();

    // Table write in the same cycle as the accept must be seen by that sample.
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = '0;
    bus.cfg_lx  = '0;
    bus.cfg_ly  = '0;
    bus.cfg_lz  = W'(32767);
    bus.cfg_int = W'(32767);
    issue("diffuse", 16384, 16384, 16384, 32767, 0, 0, 1, 1'b1, 16382, 16382, 16382, 3);
    drain("diffuse");

    cfg_write(0, 0, 0, -32767, 32767);
    issue("backface", 16384, 16384, 16384, 32767, 128, 1, 1, 1'b1, 0, 0, 0, 3);
    drain("backface");

    cfg_write(0, 0, 0, 32767, 32767);
    issue("spec_sat", 16384, 16384, 16384, 32767, 128, 1, 1, 1'b1, 32767, 32767, 32767, 3);
    drain("spec_sat");

    issue("pow2", 0, 0, 0, 32767, 128, 2, 1, 1'b1, 32763, 32763, 32763, 4);
    drain("pow2");

    for (int i = 0; i < 4; i++) cfg_write(i, 0, 0, 32767, 32767);
    issue("abort", 16384, 16384, 16384, 32767, 128, 4, 4, 1'b0, 0, 0, 0, 0);
    tick();
    check("abort_busy_before_rst", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_in_ready", int'(bus.in_ready), 1);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_out_r", int'(bus.out_r), 0);
    check("abort_out_g", int'(bus.out_g), 0);
    check("abort_out_b", int'(bus.out_b), 0);
    tick();
    rst = 1'b0;
    tick();
    issue("post_reset", 16384, 16384, 16384, 32767, 128, 1, 1, 1'b1, 0, 0, 0, 3);
    drain("post_reset");

    cfg_write(0, 0, 0, 32767, 32767);
    cfg_write(1, 0, 0, 32767, 32767);
    issue("two_lights", 8192, 8192, 8192, 32767, 0, 4, 2, 1'b1, 16380, 16380, 16380, 11);
    drain("two_lights");

    for (int i = 0; i < 4; i++) cfg_write(i, 0, 0, 32767, 8192);
    bus.out_ready = 1'b0;
    issue("clamp_bp", 8192, 8192, 8192, 32767, 0, 0, 7, 1'b1, 8188, 8188, 8188, 9);
    cfg_write(0, 0, 0, -32767, 32767);
    guard = 0;
    while (!bus.out_valid && guard < 100) begin
      tick();
      guard++;
    end
    check("clamp_bp_valid_seen", int'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", int'(bus.in_ready), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    drain("clamp_bp");

    issue("table_kept", 8192, 16384, -5, 32767, 0, 0, 1, 1'b1, 2047, 4095, 0, 3);
    drain("table_kept");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
